// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU field constants, compare opcodes and NaN helpers
package fpu_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MANT_W   = 23;

   typedef enum logic [1:0] {
      FCMP_FEQ = 2'b00,
      FCMP_FLT = 2'b01,
      FCMP_FLE = 2'b10,
      FCMP_RSV = 2'b11
   } fcmp_op_e;

   function automatic logic is_nan(input logic [31:0] x);
      return (&x[EXP_MSB:EXP_LSB]) && (x[MANT_W-1:0] != '0);
   endfunction

   // Signalling NaN has the quiet bit (top mantissa bit) clear.
   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[MANT_W-1];
   endfunction

endpackage

// File: rtl/fcmp_core.sv
// rtl/fcmp_core.sv - combinational single-precision FEQ/FLT/FLE evaluator
// Optional NaN handling enabled by FCMP_NAN_EN.
import fpu_pkg::*;

module fcmp_core (
   input  logic [1:0]  op,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        result,
   output logic        nv
);

   logic        sgn1, sgn2, both_zero, eq, lt, raw;
   logic [30:0] m1, m2;

   always_comb begin
      sgn1      = x1[SIGN_BIT];
      sgn2      = x2[SIGN_BIT];
      m1        = x1[EXP_MSB:0];
      m2        = x2[EXP_MSB:0];
      both_zero = (m1 == '0) && (m2 == '0);
      eq        = (x1 == x2) || both_zero;
      lt        = (!sgn1 && !sgn2 && (m1 < m2)) ||
                  (sgn1 && !sgn2 && !both_zero) ||
                  (sgn1 && sgn2 && (m1 > m2));
      case (fcmp_op_e'(op))
         FCMP_FEQ: raw = eq;
         FCMP_FLT: raw = lt;
         FCMP_FLE: raw = lt || eq;
         default:  raw = 1'b0;
      endcase
`ifdef FCMP_NAN_EN
      result = raw && !(is_nan(x1) || is_nan(x2));
      case (fcmp_op_e'(op))
         FCMP_FEQ: nv = is_snan(x1) || is_snan(x2);
         FCMP_FLT,
         FCMP_FLE: nv = is_nan(x1) || is_nan(x2);
         default:  nv = 1'b0;
      endcase
`else
      result = raw;
      nv     = 1'b0;
`endif
   end

endmodule

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - two-stage valid/ready FPU compare pipe with flush
// NaN semantics selected by FCMP_NAN_EN (port list identical either way).
import fpu_pkg::*;

module fcmp_pipe #(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_x1,
   input  logic [31:0]      in_x2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_nv
);

   logic             s1_valid_q, s1_valid_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic [31:0]      s1_x1_q, s1_x1_d, s1_x2_q, s1_x2_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic             s2_valid_q, s2_valid_d;
   logic             s2_res_q, s2_res_d;
   logic             s2_nv_q, s2_nv_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
   logic             s1_adv, s2_adv, core_res, core_nv;

   fcmp_core u_core (
      .op     (s1_op_q),
      .x1     (s1_x1_q),
      .x2     (s1_x2_q),
      .result (core_res),
      .nv     (core_nv)
   );

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_x1_d    = s1_x1_q;
      s1_x2_d    = s1_x2_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_nv_d    = s2_nv_q;
      s2_tag_d   = s2_tag_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_op_d  = in_op;
            s1_x1_d  = in_x1;
            s1_x2_d  = in_x2;
            s1_tag_d = in_tag;
         end
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_res_d = core_res;
            s2_nv_d  = core_nv;
            s2_tag_d = s1_tag_q;
         end
      end
      // Flush wins over a same-cycle accept; payload may load but is never presented.
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_x1_q    <= '0;
         s1_x2_q    <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= 1'b0;
         s2_nv_q    <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_x1_q    <= s1_x1_d;
         s1_x2_q    <= s1_x2_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_nv_q    <= s2_nv_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = {31'b0, s2_res_q};
   assign out_tag   = s2_tag_q;
   assign out_nv    = s2_nv_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - randomized scoreboard bench for fcmp_pipe (honours FCMP_NAN_EN)
module tb_fcmp_pipe;

   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_op = '0;
   logic [31:0]      in_x1 = '0;
   logic [31:0]      in_x2 = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_nv;

   int total = 0;
   int bad   = 0;

   fcmp_pipe #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_x1     (in_x1),
      .in_x2     (in_x2),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_nv    (out_nv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: order floats by a signed integer key (sign applied to magnitude).
   function automatic logic [37:0] ref_pack(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [TAG_W-1:0] tg);
      int  ka, kb;
      logic r, nv, na, nb;
      ka = a[31] ? -int'({1'b0, a[30:0]}) : int'({1'b0, a[30:0]});
      kb = b[31] ? -int'({1'b0, b[30:0]}) : int'({1'b0, b[30:0]});
      case (op)
         2'd0:    r = (ka == kb);
         2'd1:    r = (ka < kb);
         2'd2:    r = (ka <= kb);
         default: r = 1'b0;
      endcase
      nv = 1'b0;
`ifdef FCMP_NAN_EN
      na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      if (na || nb) r = 1'b0;
      if (op == 2'd1 || op == 2'd2) nv = na || nb;
      if (op == 2'd0) nv = (na && !a[22]) || (nb && !b[22]);
`else
      na = 1'b0;
      nb = na;
`endif
      return {31'b0, r, tg, nv};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 8))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'h3F80_0000;
         3: return 32'hBF80_0000;
         4: return 32'h7FC0_0000;
         5: return 32'h7F80_0001;
         6: return 32'h7F80_0000;
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard monitor: queue holds every accepted, not-yet-retired op.
   logic [37:0] sb_q[$];
   logic        mon_en = 1'b0;
   logic        stall_prev = 1'b0;
   logic [37:0] prev_out = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_payload", {out_data, out_tag, out_nv}, prev_out);
         end
         chk("in_ready", in_ready, (sb_q.size() < 2) || out_ready);
         if (sb_q.size() == 0) chk("idle_valid", out_valid, 0);
         if (out_valid && out_ready && sb_q.size() != 0)
            chk("result", {out_data, out_tag, out_nv}, sb_q.pop_front());
         if (flush) sb_q.delete();
         else if (in_valid && in_ready) sb_q.push_back(ref_pack(in_op, in_x1, in_x2, in_tag));
         stall_prev = out_valid && !out_ready && !flush;
         prev_out   = {out_data, out_tag, out_nv};
      end
   end

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tg);
      in_valid = v;
      in_op    = op;
      in_x1    = a;
      in_x2    = b;
      in_tag   = tg;
   endtask

   task automatic run_one(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic er, input logic env);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, op, a, b, 5'd9);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_lat1"}, out_valid, 0);
      @(negedge clk);
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_data"}, out_data, {31'b0, er});
      chk({nm, "_tag"}, out_tag, 5'd9);
      chk({nm, "_nv"}, out_nv, env);
   endtask

   initial begin
      int sent, cyc, tries;
      logic saw_block;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_tag", out_tag, 0);
      chk("rst_nv", out_nv, 0);
      @(posedge clk); #1;
      rstn = 1'b1;

      run_one("flt_1_2", 2'b01, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0);
      run_one("feq_pm0", 2'b00, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
      run_one("flt_pm0", 2'b01, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
      run_one("fle_pm0", 2'b10, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
      run_one("flt_neg", 2'b01, 32'hBF80_0000, 32'hBF00_0000, 1'b1, 1'b0);
      run_one("flt_negs", 2'b01, 32'hBF00_0000, 32'hBF80_0000, 1'b0, 1'b0);
      run_one("op_rsv", 2'b11, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);
`ifdef FCMP_NAN_EN
      run_one("nan_flt", 2'b01, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b1);
      run_one("nan_feqq", 2'b00, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0, 1'b0);
      run_one("nan_feqs", 2'b00, 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b1);
`else
      run_one("nan_flt", 2'b01, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b0);
      run_one("nan_feqq", 2'b00, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1, 1'b0);
      run_one("nan_feqs", 2'b00, 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b0);
`endif
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Back-to-back 8 ops with writeback stalled for cycles 3..5.
      sent = 0;
      saw_block = 1'b0;
      for (cyc = 0; cyc < 40 && sent < 8; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 5);
         drive(1'b1, 2'($urandom_range(0, 2)), pick(), pick(), 5'(sent));
         @(negedge clk);
         if (in_ready) sent++;
         else saw_block = 1'b1;
         @(posedge clk); #1;
      end
      chk("b2b_sent", sent, 8);
      chk("b2b_blocked", saw_block, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Flush with two ops in flight and a new op offered.
      out_ready = 1'b0;
      drive(1'b1, 2'b01, 32'h3F80_0000, 32'h4000_0000, 5'd1);
      @(posedge clk); #1;
      drive(1'b1, 2'b00, 32'h0000_0000, 32'h0000_0000, 5'd2);
      @(posedge clk); #1;
      drive(1'b1, 2'b10, 32'h4000_0000, 32'h3F80_0000, 5'd3);
      flush = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_c1", out_valid, 0);
      @(negedge clk);
      chk("flush_c2", out_valid, 0);
      @(posedge clk); #1;

      // Reset while two ops are in flight.
      out_ready = 1'b0;
      drive(1'b1, 2'b01, 32'hBF80_0000, 32'h3F80_0000, 5'd4);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      mon_en = 1'b0;
      rstn   = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      sb_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_tag", out_tag, 0);
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Randomized traffic with occasional flush.
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] a, b;
         a = pick();
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = a ^ 32'h8000_0000;
            default: b = pick();
         endcase
         flush = ($urandom_range(0, 39) == 0);
         out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
         @(posedge clk); #1;
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tries = 0;
      while (sb_q.size() != 0 && tries < 20) begin
         @(posedge clk); #1;
         tries++;
      end
      chk("drain", sb_q.size(), 0);
      @(posedge clk); #1;
      mon_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
